// File: rtl/clipper_pkg.sv
// Shared Clipper timebase constants and the nanosecond time type.
package clipper_pkg;
  localparam int TB_TIME_W = 64;
  localparam int TB_INC_NS = 8;

  typedef logic [TB_TIME_W-1:0] tb_time_t;
endpackage

// File: rtl/clipper_tick_gen.sv
// One periodic tick channel: remainder accumulator, compare/subtract, tick flop.
module clipper_tick_gen
  import clipper_pkg::*;
#(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                hold,
  input  logic                ena,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W:0]   inc,
  output logic                tick
);
  // One extra bit beyond acc+inc so the sum can never overflow.
  localparam int SUM_W = PERIOD_W + 2;

  logic [PERIOD_W-1:0] acc;
  logic [PERIOD_W-1:0] acc_nxt;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    rem;
  logic [SUM_W-1:0]    per_ext;
  logic                active;
  logic                fire;

  always_comb begin
    per_ext = {2'b00, period};
    active  = ena && (period != '0);
    sum     = {2'b00, acc} + {1'b0, inc};
    rem     = sum - per_ext;
    fire    = active && (sum >= per_ext);
    acc_nxt = acc;
    if (!active) begin
      acc_nxt = '0;
    end else if (fire) begin
      // Remainder still over the period means inc > period or the period shrank.
      acc_nxt = (rem >= per_ext) ? '0 : rem[PERIOD_W-1:0];
    end else begin
      acc_nxt = sum[PERIOD_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (hold) begin
      tick <= 1'b0;
    end else begin
      acc  <= acc_nxt;
      tick <= fire;
    end
  end
endmodule

// File: rtl/clipper_timebase_gen.sv
// Free-running ns timebase with force/accelerate/freeze control and NB_TICK tick channels.
module clipper_timebase_gen
  import clipper_pkg::*;
#(
  parameter int TIME_W      = TB_TIME_W,
  parameter int INC_NS      = TB_INC_NS,
  parameter int ACCEL_SHIFT = 10,
  parameter int NB_TICK     = 4,
  parameter int PERIOD_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         force_i,
  input  logic [TIME_W-1:0]            force_time_i,
  input  logic                         accel_i,
  input  logic                         freeze_i,
  input  logic [NB_TICK-1:0]           tick_ena_i,
  input  logic [NB_TICK*PERIOD_W-1:0]  tick_period_i,
  output logic [TIME_W-1:0]            time_o,
  output logic                         time_valid_o,
  output logic [NB_TICK-1:0]           tick_o,
  output logic                         wrap_o
);
  localparam int ACC_W = PERIOD_W + 1;

  logic [TIME_W-1:0] inc;
  logic [TIME_W:0]   sum;
  logic [ACC_W-1:0]  inc_acc;

  always_comb begin
    inc = TIME_W'(INC_NS);
    if (freeze_i) begin
      inc = '0;
    end else if (accel_i) begin
      inc = TIME_W'(INC_NS) << ACCEL_SHIFT;
    end
    sum = {1'b0, time_o} + {1'b0, inc};
  end

  // Tick channels see the increment resized to the accumulator width.
  if (TIME_W >= ACC_W) begin : g_inc_trunc
    assign inc_acc = inc[ACC_W-1:0];
  end else begin : g_inc_ext
    assign inc_acc = {{(ACC_W-TIME_W){1'b0}}, inc};
  end

  // A frozen cycle adds zero, so the carry (and wrap_o) is naturally 0 there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_o       <= '0;
      time_valid_o <= 1'b0;
      wrap_o       <= 1'b0;
    end else if (force_i) begin
      time_o       <= force_time_i;
      time_valid_o <= 1'b1;
      wrap_o       <= 1'b0;
    end else begin
      time_o       <= sum[TIME_W-1:0];
      wrap_o       <= sum[TIME_W];
    end
  end

  for (genvar k = 0; k < NB_TICK; k++) begin : g_tick
    clipper_tick_gen #(
      .PERIOD_W (PERIOD_W)
    ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .clear  (force_i),
      .hold   (freeze_i),
      .ena    (tick_ena_i[k]),
      .period (tick_period_i[k*PERIOD_W +: PERIOD_W]),
      .inc    (inc_acc),
      .tick   (tick_o[k])
    );
  end
endmodule

// File: tb/tb_clipper_timebase_gen.sv
// Directed plus random stimulus for clipper_timebase_gen with a queued expected-value scoreboard.
module tb_clipper_timebase_gen;
  import clipper_pkg::*;

  localparam int NB_TICK  = 4;
  localparam int PERIOD_W = 32;
  localparam int EXP_W    = TB_TIME_W + 1 + NB_TICK + 1;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        force_i = 1'b0;
  tb_time_t                    force_time_i = '0;
  logic                        accel_i = 1'b0;
  logic                        freeze_i = 1'b0;
  logic [NB_TICK-1:0]          tick_ena_i = '0;
  logic [NB_TICK*PERIOD_W-1:0] tick_period_i = '0;
  tb_time_t                    time_o;
  logic                        time_valid_o;
  logic [NB_TICK-1:0]          tick_o;
  logic                        wrap_o;

  clipper_timebase_gen #(
    .NB_TICK  (NB_TICK),
    .PERIOD_W (PERIOD_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .force_i       (force_i),
    .force_time_i  (force_time_i),
    .accel_i       (accel_i),
    .freeze_i      (freeze_i),
    .tick_ena_i    (tick_ena_i),
    .tick_period_i (tick_period_i),
    .time_o        (time_o),
    .time_valid_o  (time_valid_o),
    .tick_o        (tick_o),
    .wrap_o        (wrap_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EXP_W-1:0] exp_q[$];

  tb_time_t        m_time;
  logic            m_valid;
  longint unsigned m_acc[NB_TICK];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_time  = '0;
    m_valid = 1'b0;
    for (int k = 0; k < NB_TICK; k++) m_acc[k] = 0;
  endtask

  task automatic set_period(input int k, input logic [PERIOD_W-1:0] p);
    tick_period_i[k*PERIOD_W +: PERIOD_W] = p;
  endtask

  // Called just after a rising edge: drive, predict, clock once, then score.
  task automatic step(input logic frc, input tb_time_t ft, input logic acl, input logic frz);
    logic [64:0]      nsum;
    tb_time_t         inc;
    logic [NB_TICK-1:0] etick;
    logic             ewrap;
    longint unsigned  s;
    longint unsigned  per;
    logic [EXP_W-1:0] e;
    force_i      = frc;
    force_time_i = ft;
    accel_i      = acl;
    freeze_i     = frz;
    inc   = frz ? 64'd0 : (acl ? (64'(TB_INC_NS) << 10) : 64'(TB_INC_NS));
    etick = '0;
    ewrap = 1'b0;
    if (frc) begin
      m_time  = ft;
      m_valid = 1'b1;
      for (int k = 0; k < NB_TICK; k++) m_acc[k] = 0;
    end else begin
      nsum   = {1'b0, m_time} + {1'b0, inc};
      m_time = nsum[63:0];
      ewrap  = nsum[64];
      if (!frz) begin
        for (int k = 0; k < NB_TICK; k++) begin
          per = 64'(tick_period_i[k*PERIOD_W +: PERIOD_W]);
          if (!tick_ena_i[k] || per == 0) begin
            m_acc[k] = 0;
          end else begin
            s = m_acc[k] + inc;
            if (s >= per) begin
              etick[k] = 1'b1;
              s = s - per;
              m_acc[k] = (s >= per) ? 0 : s;
            end else begin
              m_acc[k] = s;
            end
          end
        end
      end
    end
    exp_q.push_back({m_time, m_valid, etick, ewrap});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("sb_time",  time_o,       e[EXP_W-1 -: 64]);
    check("sb_valid", time_valid_o, 64'(e[NB_TICK+1]));
    check("sb_tick",  tick_o,       64'(e[NB_TICK:1]));
    check("sb_wrap",  wrap_o,       64'(e[0]));
  endtask

  logic [9:0] hist;

  initial begin
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_time",  time_o, 64'd0);
    check("rst_valid", time_valid_o, 64'd0);
    check("rst_tick",  tick_o, 64'd0);
    check("rst_wrap",  wrap_o, 64'd0);
    rst = 1'b0;

    repeat (10) step(1'b0, '0, 1'b0, 1'b0);
    check("run10_time",  time_o, 64'd80);
    check("run10_valid", time_valid_o, 64'd0);
    check("run10_tick",  tick_o, 64'd0);

    step(1'b1, 64'h1000, 1'b0, 1'b0);
    check("force_time",  time_o, 64'h1000);
    check("force_valid", time_valid_o, 64'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("force_next", time_o, 64'h1008);

    // channel 0, period 20 (2.5 clocks)
    tick_ena_i = 4'b0001;
    set_period(0, 32'd20);
    step(1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      hist[i] = tick_o[0];
    end
    check("ch0_tick_pattern", 64'(hist), 64'h294);

    step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("wrap_time", time_o, 64'd0);
    check("wrap_pulse", wrap_o, 64'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    check("wrap_single", wrap_o, 64'd0);

    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    check("accel_time", time_o, 64'd16392);

    step(1'b1, 64'h5000, 1'b0, 1'b1);
    check("frz_force_time", time_o, 64'h5000);
    check("frz_force_tick", tick_o, 64'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    check("frz_hold_time", time_o, 64'h5000);
    check("frz_hold_tick", tick_o, 64'd0);

    // channel 1 with period shorter than the increment
    tick_ena_i = 4'b0011;
    set_period(1, 32'd4);
    step(1'b1, '0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      check("ch1_every_cycle", 64'(tick_o[1]), 64'd1);
    end

    for (int i = 0; i < 40; i++) begin
      tick_ena_i = NB_TICK'($urandom_range(0, 15));
      for (int k = 0; k < NB_TICK; k++) set_period(k, PERIOD_W'($urandom_range(0, 60)));
      step(($urandom_range(0, 9) == 0), {$urandom, $urandom},
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    // asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    check("midrst_time",  time_o, 64'd0);
    check("midrst_valid", time_valid_o, 64'd0);
    check("midrst_tick",  tick_o, 64'd0);
    check("midrst_wrap",  wrap_o, 64'd0);
    model_reset();
    rst = 1'b0;
    tick_ena_i = '0;
    step(1'b0, '0, 1'b0, 1'b0);
    check("post_rst_time", time_o, 64'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
